// File: rtl/fifo_sync_flags_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_flags_if
// Description : Handshake/status bundle for fifo_sync_flags.
//               slave  modport - the FIFO itself (takes requests, drives
//                                data and status).
//               master modport - the producer/consumer side.
//               Signals: i_wr_en, i_data, i_rd_en (requests);
//                        o_data, o_valid, o_full, o_empty, o_almost_full,
//                        o_almost_empty, o_count, o_overflow, o_underflow.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_sync_flags_if #(
    parameter int SIZE_DATA  = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  i_wr_en;
    logic [SIZE_DATA-1:0]  i_data;
    logic                  i_rd_en;
    logic [SIZE_DATA-1:0]  o_data;
    logic                  o_valid;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almost_full;
    logic                  o_almost_empty;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_wr_en, i_data, i_rd_en,
        input  o_data, o_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_wr_en, i_data, i_rd_en,
        output o_data, o_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_overflow, o_underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_flags
// Description : Single-clock FIFO with fill count, almost-full/almost-empty
//               thresholds, overflow/underflow pulses, read-valid strobe and
//               a compile-time standard / first-word-fall-through read mode.
// Ports       : i_clk  - clock, rising edge
//               i_rst  - asynchronous active-high reset
//               bus    - fifo_sync_flags_if.slave (requests in, data and
//                        registered status out)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_flags #(
    parameter int SIZE_DATA  = 8,
    parameter int SIZE_DEPTH = 8,
    parameter int ADDR_WIDTH = $clog2(SIZE_DEPTH),
    parameter int AF_TH      = 6,
    parameter int AE_TH      = 2,
    parameter int FWFT       = 0
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst,
    fifo_sync_flags_if.slave    bus
);

    localparam logic [ADDR_WIDTH:0] C_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] C_AF_TH = (ADDR_WIDTH+1)'(AF_TH);
    localparam logic [ADDR_WIDTH:0] C_AE_TH = (ADDR_WIDTH+1)'(AE_TH);

    logic [SIZE_DATA-1:0]  mem_q [SIZE_DEPTH];

    logic [ADDR_WIDTH:0]   ptr_wr_q, ptr_wr_d;
    logic [ADDR_WIDTH:0]   ptr_rd_q, ptr_rd_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  full_q,   full_d;
    logic                  empty_q,  empty_d;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    assign wr_ok = bus.i_wr_en & ~full_q;
    assign rd_ok = bus.i_rd_en & ~empty_q;

    always_comb begin
        ptr_wr_d = ptr_wr_q;
        ptr_rd_d = ptr_rd_q;
        count_d  = count_q;
        if (wr_ok) ptr_wr_d = ptr_wr_q + C_ONE;
        if (rd_ok) ptr_rd_d = ptr_rd_q + C_ONE;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
        // The extra MSB distinguishes full from empty when the low bits match.
        empty_d = (ptr_wr_d == ptr_rd_d);
        full_d  = (ptr_wr_d[ADDR_WIDTH-1:0] == ptr_rd_d[ADDR_WIDTH-1:0]) &&
                  (ptr_wr_d[ADDR_WIDTH]     != ptr_rd_d[ADDR_WIDTH]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_wr_q    <= '0;
            ptr_rd_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_wr_q    <= ptr_wr_d;
            ptr_rd_q    <= ptr_rd_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= (count_d >= C_AF_TH);
            aempty_q    <= (count_d <= C_AE_TH);
            overflow_q  <= bus.i_wr_en & full_q;
            underflow_q <= bus.i_rd_en & empty_q;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[ptr_wr_q[ADDR_WIDTH-1:0]] <= bus.i_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally from the memory; it is
            // only meaningful while the FIFO is non-empty.
            assign bus.o_data  = mem_q[ptr_rd_q[ADDR_WIDTH-1:0]];
            assign bus.o_valid = ~empty_q;
        end else begin : g_std
            logic [SIZE_DATA-1:0] data_q;
            logic                 valid_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok) begin
                        data_q <= mem_q[ptr_rd_q[ADDR_WIDTH-1:0]];
                    end
                end
            end

            assign bus.o_data  = data_q;
            assign bus.o_valid = valid_q;
        end
    endgenerate

    assign bus.o_full         = full_q;
    assign bus.o_empty        = empty_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_almost_empty = aempty_q;
    assign bus.o_count        = count_q;
    assign bus.o_overflow     = overflow_q;
    assign bus.o_underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_flags
// Description : Directed self-checking bench for fifo_sync_flags. Three
//               instances: default standard mode (u0), FWFT mode (u1) and a
//               16-deep instance with custom thresholds (u2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_flags;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fifo_sync_flags_if #(.SIZE_DATA(8), .ADDR_WIDTH(3)) bus0 ();
    fifo_sync_flags_if #(.SIZE_DATA(8), .ADDR_WIDTH(3)) bus1 ();
    fifo_sync_flags_if #(.SIZE_DATA(8), .ADDR_WIDTH(4)) bus2 ();

    fifo_sync_flags #(.SIZE_DATA(8), .SIZE_DEPTH(8), .AF_TH(6), .AE_TH(2), .FWFT(0))
        u0 (.i_clk(clk), .i_rst(rst), .bus(bus0.slave));
    fifo_sync_flags #(.SIZE_DATA(8), .SIZE_DEPTH(8), .AF_TH(6), .AE_TH(2), .FWFT(1))
        u1 (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));
    fifo_sync_flags #(.SIZE_DATA(8), .SIZE_DEPTH(16), .AF_TH(12), .AE_TH(3), .FWFT(0))
        u2 (.i_clk(clk), .i_rst(rst), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus drivers: apply inputs, pass one rising edge, settle 1 time unit.
    task automatic drive0(input logic wr, input logic [7:0] d, input logic rd);
        bus0.i_wr_en = wr; bus0.i_data = d; bus0.i_rd_en = rd;
        @(posedge clk); #1;
    endtask

    task automatic drive1(input logic wr, input logic [7:0] d, input logic rd);
        bus1.i_wr_en = wr; bus1.i_data = d; bus1.i_rd_en = rd;
        @(posedge clk); #1;
    endtask

    task automatic drive2(input logic wr, input logic [7:0] d, input logic rd);
        bus2.i_wr_en = wr; bus2.i_data = d; bus2.i_rd_en = rd;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus0.o_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got=%b exp=1", bus0.o_empty); end
        n_checks++; if (bus0.o_count !== 4'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus0.o_count); end
        n_checks++; if (bus0.o_full !== 1'b0) begin n_fail++; $display("FAIL rst_full got=%b exp=0", bus0.o_full); end
        n_checks++; if (bus0.o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_aempty got=%b exp=1", bus0.o_almost_empty); end
        n_checks++; if (bus0.o_almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_afull got=%b exp=0", bus0.o_almost_full); end
        n_checks++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", bus0.o_valid); end
        n_checks++; if (bus0.o_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got=%h exp=00", bus0.o_data); end
        n_checks++; if ({bus0.o_overflow, bus0.o_underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_errs got=%b exp=00", {bus0.o_overflow, bus0.o_underflow}); end
        rst = 1'b0;

        // Store 4, read 1: three words remain and o_valid is high.
        for (int i = 0; i < 4; i++) drive0(1'b1, 8'(8'h11 + i), 1'b0);
        drive0(1'b0, 8'h00, 1'b1);
        n_checks++; if (bus0.o_count !== 4'd3) begin n_fail++; $display("FAIL pre_rst_count got=%0d exp=3", bus0.o_count); end
        n_checks++; if (bus0.o_valid !== 1'b1 || bus0.o_data !== 8'h11) begin n_fail++; $display("FAIL pre_rst_read got=%b/%h exp=1/11", bus0.o_valid, bus0.o_data); end
        bus0.i_rd_en = 1'b0;

        // Asynchronous: effect visible before the next clock edge.
        #1 rst = 1'b1;
        #1;
        n_checks++; if (bus0.o_empty !== 1'b1) begin n_fail++; $display("FAIL async_empty got=%b exp=1", bus0.o_empty); end
        n_checks++; if (bus0.o_count !== 4'd0) begin n_fail++; $display("FAIL async_count got=%0d exp=0", bus0.o_count); end
        n_checks++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", bus0.o_valid); end
        n_checks++; if (bus0.o_almost_empty !== 1'b1 || bus0.o_full !== 1'b0) begin n_fail++; $display("FAIL async_flags got=ae%b/f%b exp=ae1/f0", bus0.o_almost_empty, bus0.o_full); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive0(1'b0, 8'h00, 1'b1);
        n_checks++; if (bus0.o_underflow !== 1'b1) begin n_fail++; $display("FAIL post_rst_underflow got=%b exp=1", bus0.o_underflow); end
        n_checks++; if (bus0.o_valid !== 1'b0 || bus0.o_count !== 4'd0) begin n_fail++; $display("FAIL post_rst_read got=v%b/c%0d exp=v0/c0", bus0.o_valid, bus0.o_count); end
        drive0(1'b0, 8'h00, 1'b0);
        n_checks++; if (bus0.o_underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_pulse_width got=%b exp=0", bus0.o_underflow); end
    endtask

    task automatic test_fill;
        logic [3:0] ec;
        for (int k = 1; k <= 9; k++) begin
            drive0(1'b1, 8'(k), 1'b0);
            ec = (k < 8) ? 4'(k) : 4'd8;
            n_checks++; if (bus0.o_count !== ec) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", k, bus0.o_count, ec); end
            n_checks++; if (bus0.o_almost_full !== (ec >= 4'd6)) begin n_fail++; $display("FAIL fill_afull[%0d] got=%b exp=%b", k, bus0.o_almost_full, ec >= 4'd6); end
            n_checks++; if (bus0.o_almost_empty !== (ec <= 4'd2)) begin n_fail++; $display("FAIL fill_aempty[%0d] got=%b exp=%b", k, bus0.o_almost_empty, ec <= 4'd2); end
            n_checks++; if (bus0.o_full !== (ec == 4'd8)) begin n_fail++; $display("FAIL fill_full[%0d] got=%b exp=%b", k, bus0.o_full, ec == 4'd8); end
            n_checks++; if (bus0.o_overflow !== (k == 9)) begin n_fail++; $display("FAIL fill_overflow[%0d] got=%b exp=%b", k, bus0.o_overflow, k == 9); end
        end
        bus0.i_wr_en = 1'b0;
    endtask

    task automatic test_drain;
        logic [3:0] ec;
        for (int k = 1; k <= 8; k++) begin
            drive0(1'b0, 8'h00, 1'b1);
            ec = 4'(8 - k);
            n_checks++; if (bus0.o_data !== 8'(k) || bus0.o_valid !== 1'b1) begin n_fail++; $display("FAIL drain_data[%0d] got=%h/v%b exp=%h/v1", k, bus0.o_data, bus0.o_valid, 8'(k)); end
            n_checks++; if (bus0.o_count !== ec) begin n_fail++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, bus0.o_count, ec); end
            n_checks++; if (bus0.o_almost_empty !== (ec <= 4'd2)) begin n_fail++; $display("FAIL drain_aempty[%0d] got=%b exp=%b", k, bus0.o_almost_empty, ec <= 4'd2); end
            n_checks++; if (bus0.o_empty !== (ec == 4'd0)) begin n_fail++; $display("FAIL drain_empty[%0d] got=%b exp=%b", k, bus0.o_empty, ec == 4'd0); end
            n_checks++; if (bus0.o_underflow !== 1'b0) begin n_fail++; $display("FAIL drain_underflow[%0d] got=%b exp=0", k, bus0.o_underflow); end
        end
        drive0(1'b0, 8'h00, 1'b1);
        n_checks++; if (bus0.o_underflow !== 1'b1) begin n_fail++; $display("FAIL drain9_underflow got=%b exp=1", bus0.o_underflow); end
        n_checks++; if (bus0.o_valid !== 1'b0 || bus0.o_data !== 8'h08) begin n_fail++; $display("FAIL drain9_hold got=v%b/%h exp=v0/08", bus0.o_valid, bus0.o_data); end
        bus0.i_rd_en = 1'b0;
    endtask

    task automatic test_simultaneous;
        logic [7:0] ed;
        logic [7:0] tail [7];
        tail = '{8'h71, 8'h72, 8'h73, 8'h80, 8'h81, 8'h82, 8'h83};

        // Empty: write accepted, read rejected.
        drive0(1'b1, 8'h50, 1'b1);
        n_checks++; if (bus0.o_count !== 4'd1 || bus0.o_underflow !== 1'b1) begin n_fail++; $display("FAIL simul_empty got=c%0d/u%b exp=c1/u1", bus0.o_count, bus0.o_underflow); end
        n_checks++; if (bus0.o_valid !== 1'b0) begin n_fail++; $display("FAIL simul_empty_valid got=%b exp=0", bus0.o_valid); end
        for (int i = 1; i < 4; i++) drive0(1'b1, 8'(8'h50 + i), 1'b0);

        // Count 4, 20 cycles of write+read across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            drive0(1'b1, 8'(8'h60 + i), 1'b1);
            ed = (i < 4) ? 8'(8'h50 + i) : 8'(8'h60 + i - 4);
            n_checks++; if (bus0.o_data !== ed || bus0.o_valid !== 1'b1) begin n_fail++; $display("FAIL simul_data[%0d] got=%h/v%b exp=%h/v1", i, bus0.o_data, bus0.o_valid, ed); end
            n_checks++; if (bus0.o_count !== 4'd4) begin n_fail++; $display("FAIL simul_count[%0d] got=%0d exp=4", i, bus0.o_count); end
        end

        for (int i = 0; i < 4; i++) drive0(1'b1, 8'(8'h80 + i), 1'b0);
        n_checks++; if (bus0.o_full !== 1'b1 || bus0.o_count !== 4'd8) begin n_fail++; $display("FAIL simul_fill got=f%b/c%0d exp=f1/c8", bus0.o_full, bus0.o_count); end

        // Full: read accepted, write (0x99) rejected.
        drive0(1'b1, 8'h99, 1'b1);
        n_checks++; if (bus0.o_count !== 4'd7 || bus0.o_overflow !== 1'b1) begin n_fail++; $display("FAIL simul_full got=c%0d/o%b exp=c7/o1", bus0.o_count, bus0.o_overflow); end
        n_checks++; if (bus0.o_data !== 8'h70 || bus0.o_full !== 1'b0) begin n_fail++; $display("FAIL simul_full_data got=%h/f%b exp=70/f0", bus0.o_data, bus0.o_full); end

        for (int i = 0; i < 7; i++) begin
            drive0(1'b0, 8'h00, 1'b1);
            n_checks++; if (bus0.o_data !== tail[i]) begin n_fail++; $display("FAIL simul_tail[%0d] got=%h exp=%h", i, bus0.o_data, tail[i]); end
        end
        n_checks++; if (bus0.o_empty !== 1'b1) begin n_fail++; $display("FAIL simul_final_empty got=%b exp=1", bus0.o_empty); end
        bus0.i_rd_en = 1'b0;
    endtask

    task automatic test_fwft;
        n_checks++; if (bus1.o_empty !== 1'b1 || bus1.o_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_idle got=e%b/v%b exp=e1/v0", bus1.o_empty, bus1.o_valid); end
        drive1(1'b1, 8'h29, 1'b0);
        n_checks++; if (bus1.o_empty !== 1'b0 || bus1.o_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_first_flags got=e%b/v%b exp=e0/v1", bus1.o_empty, bus1.o_valid); end
        n_checks++; if (bus1.o_data !== 8'h29) begin n_fail++; $display("FAIL fwft_first_data got=%h exp=29", bus1.o_data); end
        drive1(1'b1, 8'h2A, 1'b0);
        n_checks++; if (bus1.o_data !== 8'h29 || bus1.o_count !== 4'd2) begin n_fail++; $display("FAIL fwft_hold got=%h/c%0d exp=29/c2", bus1.o_data, bus1.o_count); end
        drive1(1'b0, 8'h00, 1'b1);
        n_checks++; if (bus1.o_data !== 8'h2A || bus1.o_count !== 4'd1) begin n_fail++; $display("FAIL fwft_pop got=%h/c%0d exp=2a/c1", bus1.o_data, bus1.o_count); end
        drive1(1'b0, 8'h00, 1'b1);
        n_checks++; if (bus1.o_empty !== 1'b1 || bus1.o_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_drained got=e%b/v%b exp=e1/v0", bus1.o_empty, bus1.o_valid); end
        bus1.i_rd_en = 1'b0;
    endtask

    task automatic test_thresholds;
        logic [4:0] ec;
        for (int k = 1; k <= 16; k++) begin
            drive2(1'b1, 8'(k), 1'b0);
            ec = 5'(k);
            n_checks++; if (bus2.o_almost_full !== (ec >= 5'd12)) begin n_fail++; $display("FAIL th_up_afull[%0d] got=%b exp=%b", k, bus2.o_almost_full, ec >= 5'd12); end
            n_checks++; if (bus2.o_almost_empty !== (ec <= 5'd3)) begin n_fail++; $display("FAIL th_up_aempty[%0d] got=%b exp=%b", k, bus2.o_almost_empty, ec <= 5'd3); end
        end
        n_checks++; if (bus2.o_full !== 1'b1 || bus2.o_count !== 5'd16) begin n_fail++; $display("FAIL th_full got=f%b/c%0d exp=f1/c16", bus2.o_full, bus2.o_count); end
        for (int k = 15; k >= 0; k--) begin
            drive2(1'b0, 8'h00, 1'b1);
            ec = 5'(k);
            n_checks++; if (bus2.o_almost_full !== (ec >= 5'd12)) begin n_fail++; $display("FAIL th_dn_afull[%0d] got=%b exp=%b", k, bus2.o_almost_full, ec >= 5'd12); end
            n_checks++; if (bus2.o_almost_empty !== (ec <= 5'd3)) begin n_fail++; $display("FAIL th_dn_aempty[%0d] got=%b exp=%b", k, bus2.o_almost_empty, ec <= 5'd3); end
            n_checks++; if (bus2.o_data !== 8'(16 - k)) begin n_fail++; $display("FAIL th_dn_data[%0d] got=%h exp=%h", k, bus2.o_data, 8'(16 - k)); end
        end
        bus2.i_rd_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus0.i_wr_en = 1'b0; bus0.i_data = 8'h00; bus0.i_rd_en = 1'b0;
        bus1.i_wr_en = 1'b0; bus1.i_data = 8'h00; bus1.i_rd_en = 1'b0;
        bus2.i_wr_en = 1'b0; bus2.i_data = 8'h00; bus2.i_rd_en = 1'b0;
        #1;
        test_reset;
        test_fill;
        test_drain;
        test_simultaneous;
        test_fwft;
        test_thresholds;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
